// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
//   Multi-channel programmable clock divider. Each channel divides clk by its
//   own runtime-loadable divisor D, giving a ~50 % duty clock (high for
//   floor(D/2) cycles, low for ceil(D/2)) and a one-cycle tick at every period
//   start. New divisors are staged and applied only at the channel's period
//   boundary, so the running period always completes. D = 0 stops a channel.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   cfg_valid  divisor update request
//   cfg_ready  request for cfg_chan can be accepted (no update outstanding)
//   cfg_chan   target channel; values >= CHANNELS are accepted and dropped
//   cfg_div    new divisor (0 stops the channel)
//   sync       restart every running channel at phase 0
//   clk_out    divided clocks, registered
//   tick       period-start strobes, registered
// ---------------------------------------------------------------------------

// One divider channel. Holds the active divisor, a single pending divisor
// slot and the phase counter.
module clock_divider_lane #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
    input  logic             sync,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt, div, pdiv;
    logic [WIDTH-1:0] cnt_nxt, div_nxt;
    logic             wrap, pend_clr, tick_nxt, clk_nxt;

    always_comb begin
        cnt_nxt  = cnt;
        div_nxt  = div;
        pend_clr = 1'b0;
        wrap     = 1'b0;
        tick_nxt = 1'b0;
        if (div == '0) begin
            // Stopped: counter parked at 0, sync has no effect. A staged
            // divisor restarts the channel right away at phase 0.
            cnt_nxt = '0;
            if (pend) begin
                div_nxt  = pdiv;
                pend_clr = 1'b1;
                tick_nxt = |pdiv;
            end
        end else begin
            wrap = (cnt == div - 1'b1) | sync;
            if (wrap) begin
                cnt_nxt = '0;
                if (pend) begin
                    div_nxt  = pdiv;
                    pend_clr = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            tick_nxt = wrap;
        end
        // Outputs come from next-state values so they line up with cnt.
        // With div_nxt of 0 or 1 the compare is always false.
        clk_nxt = (cnt_nxt < (div_nxt >> 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // cnt starts at div-1 so the first edge after reset is a wrap.
            cnt     <= WIDTH'(DEFAULT_DIV - 1);
            div     <= WIDTH'(DEFAULT_DIV);
            pdiv    <= '0;
            pend    <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            div     <= div_nxt;
            tick    <= tick_nxt;
            clk_out <= clk_nxt;
            // load needs pend == 0 and pend_clr needs pend == 1, so they
            // never coincide; an accept during a wrap waits for the next one.
            if (load) begin
                pdiv <= load_div;
                pend <= 1'b1;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

module clock_divider_multi #(
    parameter int  CHANNELS    = 4,
    parameter int  WIDTH       = 8,
    parameter int  DEFAULT_DIV = 2,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                sync,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] sel, load, pend;

    // Out-of-range cfg_chan selects no lane: ready stays 1 and the request
    // is swallowed without touching any state.
    assign cfg_ready = ~|(sel & pend);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        assign sel[i]  = (cfg_chan == CW'(i));
        assign load[i] = cfg_valid & sel[i] & ~pend[i];

        clock_divider_lane #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .load_div (cfg_div),
            .sync     (sync),
            .pend     (pend[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi (CHANNELS=4, WIDTH=8, DEFAULT_DIV=2).
// The reference model tracks each channel as a position within its current
// period; outputs are derived from that position.
module tb_clock_divider_multi;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int DEF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [W-1:0]  cfg_div;
    logic          sync;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    int            m_div  [CH];
    int            m_ph   [CH];
    int            m_pdiv [CH];
    bit            m_pend [CH];
    logic [CH-1:0] e_clk, e_tick;

    always #5 clk = ~clk;

    clock_divider_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_div[i]  = DEF;
            m_ph[i]   = DEF - 1;
            m_pdiv[i] = 0;
            m_pend[i] = 1'b0;
        end
        e_clk  = '0;
        e_tick = '0;
    endtask

    // One clock period of the model, using the inputs held at this edge.
    task automatic model_step();
        int c;
        bit acc;
        bit boundary;
        c   = int'(cfg_chan);
        acc = cfg_valid && (c < CH) && !m_pend[c];
        for (int i = 0; i < CH; i++) begin
            if (m_div[i] == 0) begin
                e_tick[i] = 1'b0;
                if (m_pend[i]) begin
                    m_div[i]  = m_pdiv[i];
                    m_pend[i] = 1'b0;
                    e_tick[i] = (m_div[i] != 0);
                end
                m_ph[i] = 0;
            end else begin
                boundary = sync || (m_ph[i] == m_div[i] - 1);
                if (boundary) begin
                    m_ph[i] = 0;
                    if (m_pend[i]) begin
                        m_div[i]  = m_pdiv[i];
                        m_pend[i] = 1'b0;
                    end
                end else begin
                    m_ph[i] = m_ph[i] + 1;
                end
                e_tick[i] = boundary;
            end
            e_clk[i] = (m_ph[i] < m_div[i] / 2);
        end
        if (acc) begin
            m_pend[c] = 1'b1;
            m_pdiv[c] = int'(cfg_div);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0; sync = 1'b0;
        model_reset();
        #23;
        tests_run++;
        if (clk_out !== 4'h0 || tick !== 4'h0 || cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset clk_out=%b tick=%b rdy=%b expected 0000 0000 1",
                     clk_out, tick, cfg_ready);
        end
        rst = 1'b1;
    endtask

    task automatic test_default();
        logic [CH-1:0] want;
        for (int k = 1; k <= 8; k++) begin
            step();
            want = (k % 2 == 1) ? 4'hF : 4'h0;
            tests_run++;
            if (clk_out !== want || tick !== want || clk_out !== e_clk || tick !== e_tick) begin
                tests_failed++;
                $display("FAIL default_cyc%0d clk_out=%b tick=%b expected %b %b",
                         k, clk_out, tick, want, want);
            end
        end
    endtask

    task automatic test_reconfig();
        bit qc[$], qt[$];
        int first;
        bit wc, wt;
        step();  // land mid-period on channel 1
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            qc.push_back(clk_out[1]);
            qt.push_back(tick[1]);
            tests_run++;
            if (clk_out !== e_clk || tick !== e_tick) begin
                tests_failed++;
                $display("FAIL reconfig_model_cyc%0d clk_out=%b tick=%b expected %b %b",
                         k, clk_out, tick, e_clk, e_tick);
            end
        end
        first = -1;
        for (int k = 0; k < 3; k++) if (first < 0 && qt[k]) first = k;
        tests_run++;
        if (first < 0) begin
            tests_failed++;
            $display("FAIL reconfig_latency no tick within 3 cycles, expected one");
        end else begin
            for (int k = 0; k < 10; k++) begin
                wc = ((k % 5) < 2);
                wt = ((k % 5) == 0);
                if (qc[first+k] !== wc || qt[first+k] !== wt) begin
                    tests_failed++;
                    $display("FAIL reconfig_pattern pos%0d clk=%b tick=%b expected %b %b",
                             k, qc[first+k], qt[first+k], wc, wt);
                    break;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit qc[$], qt[$];
        int stalls, first;
        bit done, take;
        logic [15:0] pat_c, pat_t;
        pat_c = 16'b1100_111000_111000;
        pat_t = 16'b1000_100000_100000;
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = 8'd4;
        step();
        cfg_div = 8'd6;
        stalls = 0; done = 1'b0;
        for (int k = 0; k < 24; k++) begin
            take = 1'b0;
            if (!done) begin
                tests_run++;
                if (cfg_ready !== !m_pend[2]) begin
                    tests_failed++;
                    $display("FAIL b2b_ready_cyc%0d cfg_ready=%b expected %b",
                             k, cfg_ready, !m_pend[2]);
                end
                if (cfg_ready) take = 1'b1; else stalls++;
            end
            step();
            if (take) begin cfg_valid = 1'b0; done = 1'b1; end
            qc.push_back(clk_out[2]);
            qt.push_back(tick[2]);
            tests_run++;
            if (clk_out !== e_clk || tick !== e_tick) begin
                tests_failed++;
                $display("FAIL b2b_model_cyc%0d clk_out=%b tick=%b expected %b %b",
                         k, clk_out, tick, e_clk, e_tick);
            end
        end
        cfg_valid = 1'b0;
        tests_run++;
        if (stalls < 1 || !done) begin
            tests_failed++;
            $display("FAIL b2b_stall stalls=%0d done=%b expected >=1 and 1", stalls, done);
        end
        first = -1;
        for (int k = 0; k < 3; k++) if (first < 0 && qt[k]) first = k;
        tests_run++;
        if (first < 0) begin
            tests_failed++;
            $display("FAIL b2b_latency no tick within 3 cycles, expected one");
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (qc[first+k] !== pat_c[15-k] || qt[first+k] !== pat_t[15-k]) begin
                    tests_failed++;
                    $display("FAIL b2b_pattern pos%0d clk=%b tick=%b expected %b %b",
                             k, qc[first+k], qt[first+k], pat_c[15-k], pat_t[15-k]);
                    break;
                end
            end
        end
    endtask

    task automatic test_sync();
        int guard;
        cfg_valid = 1'b1;
        cfg_chan = 2'd0; cfg_div = 8'd3; step();
        cfg_chan = 2'd1; cfg_div = 8'd4; step();
        cfg_chan = 2'd2; cfg_div = 8'd7; step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            tests_run++;
            if (clk_out !== e_clk || tick !== e_tick) begin
                tests_failed++;
                $display("FAIL sync_pre_cyc%0d clk_out=%b tick=%b expected %b %b",
                         k, clk_out, tick, e_clk, e_tick);
            end
        end
        // line sync up with channel 1's natural wrap
        guard = 0;
        while (m_ph[1] != 3 && guard < 10) begin step(); guard++; end
        sync = 1'b1;
        step();
        sync = 1'b0;
        tests_run++;
        if (tick !== 4'hF || clk_out !== 4'hF || tick !== e_tick) begin
            tests_failed++;
            $display("FAIL sync_align tick=%b clk_out=%b expected 1111 1111", tick, clk_out);
        end
        step();
        tests_run++;
        if (tick !== 4'h0 || clk_out !== e_clk) begin
            tests_failed++;
            $display("FAIL sync_single_tick tick=%b clk_out=%b expected 0000 %b",
                     tick, clk_out, e_clk);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            tests_run++;
            if (clk_out !== e_clk || tick !== e_tick) begin
                tests_failed++;
                $display("FAIL sync_post_cyc%0d clk_out=%b tick=%b expected %b %b",
                         k, clk_out, tick, e_clk, e_tick);
            end
        end
    endtask

    task automatic test_stop_and_d1();
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();  // let the old period finish
        for (int k = 0; k < 10; k++) begin
            sync = (k == 3);
            step();
            sync = 1'b0;
            tests_run++;
            if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0 ||
                clk_out !== e_clk || tick !== e_tick) begin
                tests_failed++;
                $display("FAIL stop_cyc%0d clk_out=%b tick=%b expected x0 x0 (%b %b)",
                         k, clk_out, tick, e_clk, e_tick);
            end
        end
        cfg_valid = 1'b1; cfg_div = 8'd1;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            tests_run++;
            if (tick[0] !== 1'b1 || clk_out[0] !== 1'b0 ||
                clk_out !== e_clk || tick !== e_tick) begin
                tests_failed++;
                $display("FAIL d1_cyc%0d clk_out=%b tick=%b expected ch0 clk 0 tick 1",
                         k, clk_out, tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_div = 8'd9;
        step();
        cfg_valid = 1'b0;
        tests_run++;
        if (cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_pending cfg_ready=%b expected 0", cfg_ready);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (clk_out !== 4'h0 || tick !== 4'h0 || cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_async clk_out=%b tick=%b rdy=%b expected 0000 0000 1",
                     clk_out, tick, cfg_ready);
        end
        #2 rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            tests_run++;
            if (clk_out[3] !== 1'(k % 2) || clk_out !== e_clk ||
                tick !== e_tick || cfg_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL rstmid_cyc%0d clk_out=%b tick=%b rdy=%b expected %b %b 1",
                         k, clk_out, tick, cfg_ready, e_clk, e_tick);
            end
        end
    endtask

    task automatic test_random();
        bit e_rdy;
        for (int k = 0; k < 400; k++) begin
            cfg_valid = ($urandom_range(0, 9) < 3);
            cfg_chan  = 2'($urandom_range(0, 3));
            cfg_div   = 8'($urandom_range(0, 12));
            sync      = ($urandom_range(0, 19) == 0);
            #0;
            e_rdy = !m_pend[cfg_chan];
            tests_run++;
            if (cfg_ready !== e_rdy) begin
                tests_failed++;
                $display("FAIL random_ready_cyc%0d cfg_ready=%b expected %b", k, cfg_ready, e_rdy);
            end
            step();
            tests_run++;
            if (clk_out !== e_clk || tick !== e_tick) begin
                tests_failed++;
                $display("FAIL random_cyc%0d clk_out=%b tick=%b expected %b %b",
                         k, clk_out, tick, e_clk, e_tick);
            end
        end
        cfg_valid = 1'b0; sync = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_reconfig();
        test_back_to_back();
        test_sync();
        test_stop_and_d1();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
